// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    HOLD     = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller: issues one imem request,
// waits for its response, holds the instruction until decode accepts it.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               br_sel_i,
  input  logic [31:0]        br_tgt_i,
  input  logic               stall_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        instr_pc_o,
  input  logic               instr_ready_i,
  output logic [31:0]        pc_o,
  output logic [31:0]        retire_cnt_o
);

  // Handshakes: a request transfers on an edge where imem_req_o && imem_gnt_i;
  // an instruction transfers on an edge where instr_valid_o && instr_ready_i
  // && !stall_i. Responses count only in WAIT_RSP.

  fetch_state_e       state_q;
  logic               kill_q;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        instr_pc_q;
  logic               valid_q;
  logic [31:0]        retire_q;

  logic        redirect;
  logic        gnt_acc;
  logic        accept;
  logic [31:0] br_pc;

  assign imem_req_o = (state_q == REQ) && !stall_i;
  assign gnt_acc    = imem_req_o && imem_gnt_i;
  assign accept     = (state_q == HOLD) && instr_ready_i && !stall_i;
  assign redirect   = br_sel_i && (state_q != IDLE);
  assign br_pc      = {br_tgt_i[31:2], 2'b00};

  // A redirect wins over the +4 step even when the request is granted.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = br_pc;
    end else if (gnt_acc) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      retire_q   <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (gnt_acc) begin
            instr_pc_q <= pc_q;
            kill_q     <= redirect;
            state_q    <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (imem_rvalid_i) begin
            kill_q <= 1'b0;
            if (redirect || kill_q) begin
              state_q <= REQ;
            end else begin
              instr_q <= imem_rdata_i;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
          end else if (redirect) begin
            kill_q <= 1'b1;
          end
        end
        HOLD: begin
          // The held instruction still retires if decode takes it alongside its own branch.
          if (accept) begin
            retire_q <= retire_q + 32'd1;
          end
          if (accept || redirect) begin
            valid_q <= 1'b0;
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign retire_cnt_o  = retire_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter SHALL be: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port SHALL be: clk_i  input  1  single clock, rising edge.
REQ-003 Port SHALL be: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port SHALL be: br_sel_i  input  1  redirect request, taken branch or jump.
REQ-005 Port SHALL be: br_tgt_i  input  32  redirect target from ALU.
REQ-006 Port SHALL be: stall_i  input  1  backend stall, e.g. multi-cycle FP op busy.
REQ-007 Port SHALL be: imem_req_o  output  1  instruction memory request.
REQ-008 Port SHALL be: imem_addr_o  output  32  request address.
REQ-009 Port SHALL be: imem_gnt_i  input  1  request accepted this cycle.
REQ-010 Port SHALL be: imem_rvalid_i  input  1  read data valid, at least 1 cycle after gnt.
REQ-011 Port SHALL be: imem_rdata_i  input  32  read data.
REQ-012 Port SHALL be: instr_valid_o  output  1  instruction available to decode.
REQ-013 Port SHALL be: instr_o  output  32  fetched instruction.
REQ-014 Port SHALL be: instr_pc_o  output  32  address of instr_o.
REQ-015 Port SHALL be: instr_ready_i  input  1  decode accepts instruction.
REQ-016 Port SHALL be: pc_o  output  32  next fetch address.
REQ-017 Port SHALL be: retire_cnt_o  output  32  count of accepted instructions.

Function
REQ-018 The block SHALL use states IDLE, REQ, WAIT_RSP and HOLD, plus a 1-bit kill flag.
REQ-019 The block SHALL keep at most one memory request outstanding.
REQ-020 IDLE: the block SHALL move to REQ on the first rising edge after reset release, with no request issued in IDLE.
REQ-021 REQ: imem_req_o SHALL equal !stall_i, and imem_addr_o SHALL equal pc_o.
REQ-022 REQ: address SHALL stay stable while the request is pending without gnt.
REQ-023 REQ: on gnt, the block SHALL latch the request address for instr_pc_o, set pc_o <= pc_o+4 (wraps mod 2^32) and go to WAIT_RSP.
REQ-024 WAIT_RSP: on rvalid with kill=0, the block SHALL register rdata into instr_o and go to HOLD.
REQ-025 WAIT_RSP: on rvalid with kill=1, the block SHALL drop the data, clear kill and go to REQ.
REQ-026 HOLD: instr_valid_o SHALL be 1, and instr_o and instr_pc_o SHALL be stable.
REQ-027 HOLD: on instr_ready_i && !stall_i, the block SHALL increment retire_cnt_o (wraps) and go to REQ.
REQ-028 instr_valid_o SHALL be 1 only in HOLD and SHALL be registered.
REQ-029 Redirect SHALL have priority over every other event in all states except IDLE.
REQ-030 Redirect SHALL set pc_o <= {br_tgt_i[31:2],2'b00}.
REQ-031 Redirect in REQ without gnt: the block SHALL stay in REQ and present the new address next cycle.
REQ-032 Redirect in REQ with gnt the same cycle: the block SHALL go to WAIT_RSP with kill=1, and pc_o SHALL take the target, not +4.
REQ-033 Redirect in WAIT_RSP without rvalid: the block SHALL stay in WAIT_RSP and set kill=1.
REQ-034 Redirect in WAIT_RSP with rvalid the same cycle: the block SHALL drop the data and go to REQ.
REQ-035 Redirect in HOLD: the block SHALL drop the held instruction without counting it, go to REQ and deassert instr_valid_o next cycle.
REQ-036 Redirect in HOLD with instr_ready_i the same cycle: the held instruction SHALL count as accepted, because the branch belongs to it.
REQ-037 Redirect in IDLE SHALL be ignored.
REQ-038 rvalid outside WAIT_RSP SHALL be ignored.

Reset
REQ-039 On rst_ni low, the block SHALL asynchronously set: state=IDLE, kill=0, pc_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, retire_cnt_o=0.
REQ-040 imem_req_o SHALL be 0 during reset and in IDLE.
REQ-041 Reset asserted mid-transaction SHALL abandon any outstanding response, and a late rvalid after reset SHALL be ignored while in IDLE/REQ.

Structure
REQ-042 Package fetch_pkg SHALL hold the state enum typedef, the instruction width (32) and the PC increment constant (4).
REQ-043 The block SHALL be a single module with no sub-module; the next-PC mux and the PC register SHALL be implemented in place.

Verification
REQ-044 Reset release, gnt the same cycle as req, rvalid 1 cycle later, ready=1 -> addresses 0x0, 0x4, 0x8 fetched, and retire_cnt_o=3 after 3 acceptances.
REQ-045 Redirect to 0x100 while in WAIT_RSP for 0x4 -> rvalid data for 0x4 dropped, next imem_addr_o=0x100, and instr_pc_o of next valid=0x100.
REQ-046 stall_i=1 for 5 cycles in HOLD with ready=1 -> instr_o stable, no imem_req_o, and retire_cnt_o unchanged until stall drops.
REQ-047 br_tgt_i=0x203 with gnt the same cycle in REQ -> pc_o=0x200, kill=1, and the first delivered instr_pc_o=0x200.
REQ-048 pc_o=0xFFFF_FFFC granted -> pc_o=0x0000_0000, and rst_ni pulsed low in WAIT_RSP -> outputs at reset values, next fetch at RESET_PC.
